// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing blocks.
// Holds the default datapath widths, the requantisation shift, the
// accumulator FSM state encoding and the activation saturation limit.
package cnn_pkg;

    localparam int N_CH    = 12;  // partial sums per output pixel
    localparam int PSUM_W  = 9;   // signed partial-sum width
    localparam int BIAS_W  = 8;   // signed bias width
    localparam int ACC_W   = 13;  // signed accumulator width
    localparam int OUT_W   = 4;   // signed activation width
    localparam int SHIFT   = 2;   // requantisation right shift (>=1)
    localparam int OUT_MAX = 7;   // largest activation after ReLU + saturation

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        POST = 2'd2
    } state_t;

endpackage

// File: rtl/requant_relu_sat.sv
// Combinational requantiser: ReLU, arithmetic right shift by SHIFT and
// saturation to OUT_MAX. Shared with the pooling stage.
//
// Build option: define PSUM_ROUND_EN to round half-up before the shift;
// otherwise the shift truncates.
//
// Ports:
//   acc  in   ACC_W  signed accumulator value
//   res  out  OUT_W  signed activation, 0..OUT_MAX
module requant_relu_sat #(
    parameter int ACC_W = 13,
    parameter int OUT_W = 4,
    parameter int SHIFT = 2
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res
);
    import cnn_pkg::OUT_MAX;

    // One extra bit so the rounding add can never wrap.
    localparam logic signed [ACC_W:0] MAX_EXT = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [OUT_W-1:0] MAX_OUT = OUT_W'(OUT_MAX);
`ifdef PSUM_ROUND_EN
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (SHIFT-1);
`endif

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        ext = {acc[ACC_W-1], acc};
`ifdef PSUM_ROUND_EN
        ext = ext + HALF;
`endif
        shifted = ext >>> SHIFT;
        // ReLU first, so saturation only has to clamp the positive side.
        if (acc[ACC_W-1])
            res = '0;
        else if (shifted > MAX_EXT)
            res = MAX_OUT;
        else
            res = shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/psum_channel_acc.sv
// Per-output-channel partial-sum accumulator. Loads a bias on start_flag,
// adds N_CH signed partial sums, then requantises (ReLU, shift,
// saturate) into a 4-bit activation held on out with a one-cycle
// end_flag pulse.
//
// Build option: PSUM_ROUND_EN selects round-half-up requantisation
// (inside requant_relu_sat); ports and latency are unchanged.
//
// Ports:
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous active-low reset
//   start_flag  in   1       begin a new pixel, load bias (wins over psum_valid)
//   bias        in   BIAS_W  signed bias, sampled with start_flag
//   psum_valid  in   1       partial sum strobe
//   psum        in   PSUM_W  signed partial sum
//   out         out  OUT_W   activation 0..7, held until the next result
//   end_flag    out  1       one-cycle pulse when out updates
//   busy        out  1       high in ACC or POST
//   err_flag    out  1       sticky: psum_valid outside ACC; cleared by start
module psum_channel_acc #(
    parameter int N_CH   = 12,
    parameter int PSUM_W = 9,
    parameter int BIAS_W = 8,
    parameter int ACC_W  = 13,
    parameter int OUT_W  = 4,
    parameter int SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_flag,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum,
    output logic signed [OUT_W-1:0]  out,
    output logic                     end_flag,
    output logic                     busy,
    output logic                     err_flag
);
    import cnn_pkg::state_t;
    import cnn_pkg::IDLE;
    import cnn_pkg::ACC;
    import cnn_pkg::POST;

    localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CH - 1);

    state_t state, next_state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [OUT_W-1:0] rq;

    requant_relu_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_rq (
        .acc (acc),
        .res (rq)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; start_flag restarts from any state.
    always_comb begin
        next_state = state;
        if (start_flag) begin
            next_state = ACC;
        end else begin
            case (state)
                ACC:     if (psum_valid && cnt == LAST) next_state = POST;
                POST:    next_state = IDLE;
                default: next_state = state;
            endcase
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: accumulator, channel counter, result and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            cnt      <= '0;
            out      <= '0;
            end_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            end_flag <= 1'b0;
            if (start_flag) begin
                // An abort in ACC/POST lands here too, so no end_flag.
                acc      <= {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
                cnt      <= '0;
                err_flag <= 1'b0;
            end else begin
                case (state)
                    ACC: begin
                        if (psum_valid) begin
                            acc <= acc + {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
                            cnt <= cnt + 1'b1;
                        end
                    end
                    POST: begin
                        out      <= rq;
                        end_flag <= 1'b1;
                        if (psum_valid) err_flag <= 1'b1;
                    end
                    default: begin
                        if (psum_valid) err_flag <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psum_channel_acc.sv
module tb_psum_channel_acc;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start_flag = 1'b0;
    logic signed [7:0] bias = '0;
    logic              psum_valid = 1'b0;
    logic signed [8:0] psum = '0;
    logic signed [3:0] out;
    logic              end_flag;
    logic              busy;
    logic              err_flag;

    int checks = 0;
    int failures = 0;
    int ef_count = 0;

`ifdef PSUM_ROUND_EN
    localparam int EXP_ACC10 = 3;
`else
    localparam int EXP_ACC10 = 2;
`endif

    psum_channel_acc dut (
        .clk        (clk),
        .reset      (reset),
        .start_flag (start_flag),
        .bias       (bias),
        .psum_valid (psum_valid),
        .psum       (psum),
        .out        (out),
        .end_flag   (end_flag),
        .busy       (busy),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (end_flag) ef_count++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        start_flag = 1'b1;
        bias = 8'(b);
        cyc();
        start_flag = 1'b0;
    endtask

    task automatic do_psum(input int p);
        psum_valid = 1'b1;
        psum = 9'(p);
        cyc();
        psum_valid = 1'b0;
    endtask

    task automatic feed(input int b, input int p, input int n);
        do_start(b);
        for (int i = 0; i < n; i++) do_psum(p);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out !== 4'sd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
        checks++; if (end_flag !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", end_flag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_flag); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        do_start(0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_acc got=%b exp=1", busy); end
        for (int i = 0; i < 11; i++) do_psum(0);
        do_psum(9);
        checks++; if (end_flag !== 1'b0) begin failures++; $display("FAIL basic_end_early got=%b exp=0", end_flag); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_post got=%b exp=1", busy); end
        cyc();
        checks++; if (end_flag !== 1'b1) begin failures++; $display("FAIL basic_end got=%b exp=1", end_flag); end
        checks++; if (out !== 4'sd2) begin failures++; $display("FAIL basic_out got=%0d exp=2", out); end
        cyc();
        checks++; if (end_flag !== 1'b0) begin failures++; $display("FAIL basic_end_len got=%b exp=0", end_flag); end
        checks++; if (out !== 4'sd2) begin failures++; $display("FAIL basic_out_hold got=%0d exp=2", out); end
    endtask

    task automatic test_round();
        feed(0, 0, 11);
        do_psum(10);
        cyc();
        checks++; if (out !== 4'(EXP_ACC10)) begin failures++; $display("FAIL round_out got=%0d exp=%0d", out, EXP_ACC10); end
        cyc();
    endtask

    task automatic test_saturate();
        feed(0, 10, 12);
        cyc();
        checks++; if (out !== 4'sd7) begin failures++; $display("FAIL sat_out got=%0d exp=7", out); end
        checks++; if (busy !== 1'b0 || end_flag !== 1'b1) begin failures++; $display("FAIL sat_busy_end got=%b%b exp=01", busy, end_flag); end
        cyc();
    endtask

    task automatic test_negative();
        feed(3, -5, 12);
        cyc();
        checks++; if (out !== 4'sd0) begin failures++; $display("FAIL neg_out got=%0d exp=0", out); end
        cyc();
    endtask

    task automatic test_extremes();
        feed(127, 200, 12);
        cyc();
        checks++; if (out !== 4'sd7) begin failures++; $display("FAIL ext_pos got=%0d exp=7", out); end
        cyc();
        feed(-128, -200, 12);
        cyc();
        checks++; if (out !== 4'sd0) begin failures++; $display("FAIL ext_neg got=%0d exp=0", out); end
        cyc();
    endtask

    task automatic test_abort();
        int c0;
        c0 = ef_count;
        feed(0, 50, 5);
        do_start(0);
        for (int i = 0; i < 12; i++) do_psum(1);
        cyc();
        checks++; if (out !== 4'sd3) begin failures++; $display("FAIL abort_out got=%0d exp=3", out); end
        cyc();
        cyc();
        checks++; if (ef_count - c0 !== 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=1", ef_count - c0); end
    endtask

    task automatic test_err();
        do_psum(100);
        checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL err_idle got=%b exp=1", err_flag); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_busy got=%b exp=0", busy); end
        // start and psum_valid together: psum must be dropped
        start_flag = 1'b1; bias = 8'sd0; psum_valid = 1'b1; psum = 9'sd100;
        cyc();
        start_flag = 1'b0; psum_valid = 1'b0;
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_flag); end
        for (int i = 0; i < 12; i++) do_psum(1);
        // psum_valid during POST is flagged but the result still lands
        do_psum(100);
        checks++; if (end_flag !== 1'b1 || out !== 4'sd3) begin failures++; $display("FAIL err_start_wins got=%0d/%b exp=3/1", out, end_flag); end
        checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL err_post got=%b exp=1", err_flag); end
        cyc();
    endtask

    task automatic test_back_to_back();
        feed(0, 10, 12);
        cyc();
        checks++; if (end_flag !== 1'b1 || out !== 4'sd7) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=7/1", out, end_flag); end
        do_start(3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        for (int i = 0; i < 12; i++) do_psum(-5);
        cyc();
        checks++; if (end_flag !== 1'b1 || out !== 4'sd0) begin failures++; $display("FAIL b2b_second got=%0d/%b exp=0/1", out, end_flag); end
        cyc();
    endtask

    task automatic test_async_reset();
        int c0;
        feed(0, 1, 12);
        cyc();
        cyc();
        c0 = ef_count;
        feed(0, 20, 6);
        #2 reset = 1'b0;
        #1;
        checks++; if (out !== 4'sd0) begin failures++; $display("FAIL areset_out got=%0d exp=0", out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
        @(posedge clk);
        #3 reset = 1'b1;
        cyc();
        cyc();
        checks++; if (ef_count !== c0) begin failures++; $display("FAIL areset_pulse got=%0d exp=%0d", ef_count, c0); end
        feed(0, 2, 12);
        cyc();
        checks++; if (end_flag !== 1'b1 || out !== 4'sd6) begin failures++; $display("FAIL areset_fresh got=%0d/%b exp=6/1", out, end_flag); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round();
        test_saturate();
        test_negative();
        test_extremes();
        test_abort();
        test_err();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
